// File: rtl/johnson_counter.sv
//------------------------------------------------------------------------------
// Module   : johnson_counter
// Purpose  : N-bit Johnson (twisted-ring) counter with a 2N-state period,
//            binary phase index, one-hot phase decode, wrap flag and
//            illegal-pattern detection with self-recovery to all-zeros.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module johnson_counter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(2 * N)
) (
  input  logic           clk,
  input  logic           clr,
  output logic [N-1:0]   out,
  output logic [PW-1:0]  phase,
  output logic [2*N-1:0] decode,
  output logic           wrap,
  output logic           illegal
);

  // Counter wide enough to hold a popcount of 0..N.
  localparam int CW = $clog2(N + 1);

  // The width must allow a shift of N-1 bits into the MSB.
  if (N < 2) begin : g_param_check
    $error("johnson_counter: N must be at least 2");
  end

  logic [N-1:0]  state;
  logic [N-1:0]  state_next;
  logic [CW-1:0] ones;
  logic [CW-1:0] turns;
  logic          valid;
  logic [PW-1:0] raw_phase;

  // Count the set bits of the current code.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + CW'(state[i]);
    end
  end

  // Count adjacent-bit transitions; every Johnson code has at most one
  // (a single boundary between a block of ones and a block of zeros).
  always_comb begin
    turns = '0;
    for (int i = 1; i < N; i++) begin
      turns = turns + CW'(state[i] ^ state[i-1]);
    end
  end

  assign valid   = (turns <= CW'(1));
  assign illegal = ~valid;

  // Rising half (MSB clear) indexes by ones count; falling half by 2N - ones.
  // The subtraction is modulo 2^PW, which is exact for every legal code.
  always_comb begin
    if (state[N-1]) begin
      raw_phase = PW'(2 * N) - PW'(ones);
    end else begin
      raw_phase = PW'(ones);
    end
  end

  assign phase = valid ? raw_phase : '0;
  assign wrap  = valid && (raw_phase == PW'(2 * N - 1));

  for (genvar k = 0; k < 2 * N; k++) begin : g_decode
    assign decode[k] = valid && (raw_phase == PW'(k));
  end

  // Shift toward the MSB with the inverted MSB fed back; a corrupted code is
  // discarded so the ring re-enters the legal sequence at zero.
  always_comb begin
    if (valid) begin
      state_next = {state[N-2:0], ~state[N-1]};
    end else begin
      state_next = '0;
    end
  end

  // State register with asynchronous clear to the all-zeros code.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= '0;
    end else begin
      state <= state_next;
    end
  end

  assign out = state;

endmodule

`default_nettype wire

// File: tb/tb_johnson_counter.sv
//------------------------------------------------------------------------------
// Module   : tb_johnson_counter
// Purpose  : Directed self-checking bench for johnson_counter at N=4, 2 and 7.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_johnson_counter;

  logic clk = 1'b0;
  logic clr4 = 1'b1;
  logic clr2 = 1'b1;
  logic clr7 = 1'b1;

  logic [3:0]  out4;
  logic [2:0]  phase4;
  logic [7:0]  decode4;
  logic        wrap4, illegal4;

  logic [1:0]  out2;
  logic [1:0]  phase2;
  logic [3:0]  decode2;
  logic        wrap2, illegal2;

  logic [6:0]  out7;
  logic [3:0]  phase7;
  logic [13:0] decode7;
  logic        wrap7, illegal7;

  int checks   = 0;
  int failures = 0;

  johnson_counter #(.N(4)) dut4 (
    .clk(clk), .clr(clr4), .out(out4), .phase(phase4),
    .decode(decode4), .wrap(wrap4), .illegal(illegal4)
  );

  johnson_counter #(.N(2)) dut2 (
    .clk(clk), .clr(clr2), .out(out2), .phase(phase2),
    .decode(decode2), .wrap(wrap2), .illegal(illegal2)
  );

  johnson_counter #(.N(7)) dut7 (
    .clk(clk), .clr(clr7), .out(out7), .phase(phase7),
    .decode(decode7), .wrap(wrap7), .illegal(illegal7)
  );

  // 10-unit period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_until(input time t);
    if (t > $time) #(t - $time);
  endtask

  // Expected Johnson code of width n at phase k (0..2n-1).
  function automatic logic [31:0] jcode(input int n, input int k);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    if (k <= n) return (32'd1 << k) - 32'd1;
    return mask & ~((32'd1 << (k - n)) - 32'd1);
  endfunction

  // Full check of the N=4 instance against a legal phase index.
  task automatic chk4(input string tag, input int k);
    chk({tag, ".out"},     32'(out4),     jcode(4, k));
    chk({tag, ".phase"},   32'(phase4),   32'(k));
    chk({tag, ".decode"},  32'(decode4),  32'd1 << k);
    chk({tag, ".wrap"},    32'(wrap4),    32'(k == 7));
    chk({tag, ".illegal"}, 32'(illegal4), 32'd0);
  endtask

  initial begin : stimulus
    logic [13:0] seen7;
    logic [3:0]  seen2;
    int          per7, per2, dup;

    // Brief clear pulse establishes the power-up zero state deterministically.
    #1;
    chk4("reset", 0);
    clr4 = 1'b0;

    // Free run: 9 edges (5..85); the 8th returns to zero, the 9th gives 0001.
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      chk($sformatf("run%0d.out", e), 32'(out4), jcode(4, e % 8));
    end
    chk4("run9", 1);
    chk("run9.decode_lit", 32'(decode4), 32'h02);

    // Asynchronous clear between edges.
    wait_until(98);
    clr4 = 1'b1;
    #1;
    chk4("async_clr", 0);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      chk($sformatf("clr_hold%0d.out", e), 32'(out4), 32'd0);
    end

    // Release; edges 135..205 walk the full sequence back to zero.
    wait_until(133);
    clr4 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      chk4($sformatf("seq%0d", e), e % 8);
    end
    chk("seq7_literal_check", 32'(jcode(4, 7)), 32'h8);

    // Corrupt the register with a non-Johnson pattern between edges.
    wait_until(208);
    force dut4.state = 4'b0101;
    #1;
    chk("ill.illegal", 32'(illegal4), 32'd1);
    chk("ill.decode",  32'(decode4),  32'd0);
    chk("ill.phase",   32'(phase4),   32'd0);
    chk("ill.wrap",    32'(wrap4),    32'd0);
    release dut4.state;
    #1;
    chk("ill_rel.illegal", 32'(illegal4), 32'd1);
    @(posedge clk); #1;
    chk4("recover0", 0);
    @(posedge clk); #1;
    chk4("recover1", 1);

    // Second illegal pattern with the clear asserted: clear wins at once.
    @(negedge clk);
    force dut4.state = 4'b1011;
    #1;
    chk("ill2.illegal", 32'(illegal4), 32'd1);
    release dut4.state;
    clr4 = 1'b1;
    #1;
    chk("ill2_clr.out", 32'(out4), 32'd0);
    chk("ill2_clr.illegal", 32'(illegal4), 32'd0);

    // N=2 and N=7 regression from a common release point.
    @(negedge clk);
    chk("n2.reset", 32'(out2), 32'd0);
    chk("n7.reset", 32'(out7), 32'd0);
    clr2 = 1'b0;
    clr7 = 1'b0;
    seen7 = 14'b1;
    seen2 = 4'b1;
    per7 = 0;
    per2 = 0;
    dup  = 0;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      chk($sformatf("n7_%0d.out", e),     32'(out7),     jcode(7, e % 14));
      chk($sformatf("n7_%0d.phase", e),   32'(phase7),   32'(e % 14));
      chk($sformatf("n7_%0d.decode", e),  32'(decode7),  32'd1 << (e % 14));
      chk($sformatf("n7_%0d.wrap", e),    32'(wrap7),    32'(e % 14 == 13));
      chk($sformatf("n7_%0d.illegal", e), 32'(illegal7), 32'd0);
      chk($sformatf("n2_%0d.out", e),     32'(out2),     jcode(2, e % 4));
      chk($sformatf("n2_%0d.phase", e),   32'(phase2),   32'(e % 4));
      chk($sformatf("n2_%0d.wrap", e),    32'(wrap2),    32'(e % 4 == 3));
      chk($sformatf("n2_%0d.illegal", e), 32'(illegal2), 32'd0);
      if (per7 == 0 && out7 == 7'd0) per7 = e;
      if (per2 == 0 && out2 == 2'd0) per2 = e;
      if (per7 == 0) begin
        if (seen7[phase7]) dup++;
        seen7[phase7] = 1'b1;
      end
      if (per2 == 0) begin
        if (seen2[phase2]) dup++;
        seen2[phase2] = 1'b1;
      end
    end
    chk("n7.period", 32'(per7), 32'd14);
    chk("n2.period", 32'(per2), 32'd4);
    chk("n7.phases_seen", 32'(seen7), 32'h3fff);
    chk("n2.phases_seen", 32'(seen2), 32'hf);
    chk("phase_duplicates", 32'(dup), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin : watchdog
    #20000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
